// File: rtl/capture_result_fifo.sv
// Capture result FIFO: turns each rising edge of capture_complete into a {first, raw, delta} entry and buffers it.
// Latency: the entry is written at the capture edge and is visible on rd_* in the following cycle (first-word-fall-through).
// Backpressure: rd_valid/rd_ready handshake; when full with no pop in the same cycle the new entry is dropped and overflow is set.
//
// Ports:
//   clk, reset        - single clock; synchronous active-high reset
//   counter           - free-running capture counter, sampled on each capture event
//   capture_complete  - level flag from the counter; one entry per rising edge
//   flush             - empties the FIFO (pointers and level to 0)
//   clear_overflow    - clears the sticky overflow flag
//   rd_ready          - consumer accepts the head entry
//   rd_valid/rd_raw/rd_delta/rd_first - head entry, all zero when empty
//   level/full/overflow/irq           - status towards the interrupt logic
module capture_result_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        counter,
    input  logic                     capture_complete,
    input  logic                     flush,
    input  logic                     clear_overflow,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_raw,
    output logic [DATA_W-1:0]        rd_delta,
    output logic                     rd_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic                     irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(IRQ_THRESH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 cc_q;
    logic [DATA_W-1:0]    last_raw_q, last_raw_d;
    logic                 have_last_q, have_last_d;
    logic                 overflow_q, overflow_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr,
    // so it needs no reset.
    logic [DATA_W-1:0]    raw_mem_q   [DEPTH];
    logic [DATA_W-1:0]    delta_mem_q [DEPTH];
    logic [DEPTH-1:0]     first_mem_q;

    // ------------------------------------------------------------------
    // Event detection and entry formation
    // ------------------------------------------------------------------
    logic                 cap_evt;
    logic                 not_empty;
    logic                 is_full;
    logic                 push_req;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [DATA_W-1:0]    new_delta;
    logic                 new_first;

    // Only the 0->1 transition of the flag counts, so a flag held high for
    // many cycles produces a single entry.
    assign cap_evt   = capture_complete & ~cc_q;

    assign not_empty = (level_q != '0);
    assign is_full   = (level_q == DEPTH_L);

    // A flush discards a coincident capture and makes any pop irrelevant.
    assign push_req  = cap_evt & ~flush;
    assign pop       = not_empty & rd_ready & ~flush;

    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok   = push_req & (~is_full | pop);
    assign drop      = push_req & is_full & ~pop;

    // Plain DATA_W-bit subtraction: wraps modulo 2^DATA_W.
    assign new_delta = have_last_q ? (counter - last_raw_q) : '0;
    assign new_first = ~have_last_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        last_raw_d  = last_raw_q;
        have_last_d = have_last_q;
        overflow_d  = overflow_q;

        // The sample history tracks every capture event, even ones that are
        // dropped or flushed, so the next delta is always relative to the
        // most recent capture.
        if (cap_evt) begin
            last_raw_d  = counter;
            have_last_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A drop in the same cycle as a clear request wins, so software
        // never misses a loss that happened while it was clearing.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q        <= 1'b0;
            last_raw_q  <= '0;
            have_last_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            cc_q        <= capture_complete;
            last_raw_q  <= last_raw_d;
            have_last_q <= have_last_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            raw_mem_q[wr_ptr_q]   <= counter;
            delta_mem_q[wr_ptr_q] <= new_delta;
            first_mem_q[wr_ptr_q] <= new_first;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated with reset so every output reads 0 while reset is asserted,
    // including the very first reset cycle before the registers clear.
    always_comb begin
        rd_valid = ~reset & not_empty;
        rd_raw   = '0;
        rd_delta = '0;
        rd_first = 1'b0;
        if (rd_valid) begin
            rd_raw   = raw_mem_q[rd_ptr_q];
            rd_delta = delta_mem_q[rd_ptr_q];
            rd_first = first_mem_q[rd_ptr_q];
        end
        level    = reset ? '0 : level_q;
        full     = ~reset & is_full;
        overflow = ~reset & overflow_q;
        irq      = ~reset & ((level_q >= THRESH_L) | overflow_q);
    end

endmodule

// File: tb/tb_capture_result_fifo.sv
// Directed bench for capture_result_fifo with a queue-based scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected entries are formed from a small reference model at each capture.
module tb_capture_result_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TH    = 1;

    typedef struct packed {
        logic          first;
        logic [DW-1:0] raw;
        logic [DW-1:0] delta;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] counter = '0;
    logic          capture_complete = 1'b0;
    logic          flush = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_raw;
    logic [DW-1:0] rd_delta;
    logic          rd_first;
    logic [2:0]    level;
    logic          full;
    logic          overflow;
    logic          irq;

    capture_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .IRQ_THRESH(TH)) dut (
        .clk              (clk),
        .reset            (reset),
        .counter          (counter),
        .capture_complete (capture_complete),
        .flush            (flush),
        .clear_overflow   (clear_overflow),
        .rd_ready         (rd_ready),
        .rd_valid         (rd_valid),
        .rd_raw           (rd_raw),
        .rd_delta         (rd_delta),
        .rd_first         (rd_first),
        .level            (level),
        .full             (full),
        .overflow         (overflow),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    // Reference model
    ent_t          q[$];
    logic          m_have = 1'b0;
    logic [DW-1:0] m_last = '0;
    logic          m_ovf  = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".level"},    level,    DW'(q.size()));
        chk({tag, ".full"},     full,     DW'(q.size() == DEPTH));
        chk({tag, ".overflow"}, overflow, DW'(m_ovf));
        chk({tag, ".irq"},      irq,      DW'((q.size() >= TH) || m_ovf));
        chk({tag, ".rd_valid"}, rd_valid, DW'(q.size() > 0));
        chk({tag, ".rd_raw"},   rd_raw,   h.raw);
        chk({tag, ".rd_delta"}, rd_delta, h.delta);
        chk({tag, ".rd_first"}, rd_first, DW'(h.first));
    endtask

    // Model of one capture event at counter value cnt; returns the entry.
    function automatic ent_t model_sample(input logic [DW-1:0] cnt);
        ent_t e;
        e.first = ~m_have;
        e.raw   = cnt;
        e.delta = m_have ? (cnt - m_last) : '0;
        m_have  = 1'b1;
        m_last  = cnt;
        return e;
    endfunction

    // One capture pulse (1 cycle high, 1 cycle low). Optional same-cycle
    // pop, flush and clear_overflow. Starts and ends on a falling edge.
    task automatic pulse(input logic [DW-1:0] cnt, input logic rdy, input logic fl, input logic clr);
        ent_t e;
        logic popped;
        counter          = cnt;
        capture_complete = 1'b1;
        rd_ready         = rdy;
        flush            = fl;
        clear_overflow   = clr;
        popped = rdy && (q.size() > 0) && !fl;
        if (popped) check_status("pulse_pop_head");
        @(negedge clk);
        e = model_sample(cnt);
        if (fl) begin
            q.delete();
            if (clr) m_ovf = 1'b0;
        end else begin
            if (popped) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back(e);
                if (clr) m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
        capture_complete = 1'b0;
        rd_ready         = 1'b0;
        flush            = 1'b0;
        clear_overflow   = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        check_status(tag);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_reset(input int n, input logic cc_hold);
        reset            = 1'b1;
        capture_complete = cc_hold;
        repeat (n) @(negedge clk);
        q.delete();
        m_have = 1'b0;
        m_last = '0;
        m_ovf  = 1'b0;
        check_status("in_reset");
        reset            = 1'b0;
        capture_complete = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ent_t e;
        @(negedge clk);

        // 1: reset with capture_complete held high -> no entry afterwards
        do_reset(2, 1'b1);
        @(negedge clk);
        check_status("after_reset");

        // 2: first capture
        pulse(32'd100, 1'b0, 1'b0, 1'b0);
        check_status("first_cap");

        // 3: second capture, delta 250, drain both
        pulse(32'd350, 1'b0, 1'b0, 1'b0);
        check_status("second_cap");
        pop_one("pop_100");
        pop_one("pop_350");
        check_status("drained");

        // 4: counter wrap
        pulse(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
        pulse(32'h0000_0010, 1'b0, 1'b0, 1'b0);
        pop_one("wrap_a");
        pop_one("wrap_b");
        check_status("wrap_drained");

        // 5: overflow with five captures and no reads
        for (int i = 0; i < 5; i++) pulse(32'd1000 + 32'(i) * 32'd100, 1'b0, 1'b0, 1'b0);
        check_status("overflowed");
        // clear with a simultaneous drop: drop wins
        pulse(32'd2000, 1'b0, 1'b0, 1'b1);
        check_status("clear_vs_drop");
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        m_ovf = 1'b0;
        check_status("cleared");
        // capture while full with a pop in the same cycle
        pulse(32'd3000, 1'b1, 1'b0, 1'b0);
        check_status("full_push_pop");
        for (int i = 0; i < 4; i++) pop_one("drain_full");
        check_status("full_drained");

        // 6: held-high flag yields exactly one entry
        capture_complete = 1'b1;
        counter = 32'd7000;
        e = model_sample(32'd7000);
        q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            counter = 32'd7001 + 32'(i);
        end
        capture_complete = 1'b0;
        @(negedge clk);
        check_status("held_high");
        pulse(32'd7500, 1'b0, 1'b0, 1'b0);
        check_status("two_entries");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        check_status("flushed");
        // capture coincident with flush is discarded but updates history
        pulse(32'd7600, 1'b0, 1'b1, 1'b0);
        check_status("flush_cap");
        pulse(32'd7700, 1'b0, 1'b0, 1'b0);
        check_status("after_flush_cap");
        pop_one("after_flush_pop");

        // reset mid-operation: next capture is first again
        pulse(32'd500, 1'b0, 1'b0, 1'b0);
        do_reset(1, 1'b0);
        check_status("mid_reset");
        pulse(32'd600, 1'b0, 1'b0, 1'b0);
        check_status("post_reset_cap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
